// File: rtl/mdu_ctrl.sv
// MDU sequencing controller: owns HI/LO, runs the multiplier (MUL_LAT cycles),
// the MADD/MSUB accumulate step and a 32-step restoring divider.
module mdu_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        req_ready,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        resp_valid,
    output logic [31:0] resp_data
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_MTHI  = 4'd10;
    localparam logic [3:0] OP_MTLO  = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_ACC, S_DIV_PRE, S_DIV_IT, S_DIV_FIX
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic        op_ok, accept, sgn, is_sub;
    logic [63:0] ma, mb, prod;
    logic [32:0] shl;
    logic        ge;
    logic [31:0] diff, a_mag, b_mag;

    assign op_ok  = (req_op != 4'd0) && (req_op <= OP_MTLO);
    assign accept = req_valid && (state_q == S_IDLE) && !flush && op_ok;
    assign sgn    = op_q inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB, OP_MUL};
    assign is_sub = op_q inside {OP_MSUB, OP_MSUBU};

    // Operands are held stable from accept to the writing edge, so the
    // multiplier is given MUL_LAT cycles as a multicycle path.
    assign ma   = {{32{sgn & a_q[31]}}, a_q};
    assign mb   = {{32{sgn & b_q[31]}}, b_q};
    assign prod = ma * mb;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign shl  = {rem_q, quo_q[31]};
    assign ge   = shl >= {1'b0, dvs_q};
    assign diff = shl[31:0] - dvs_q;

    assign a_mag = (sgn && a_q[31]) ? (~a_q + 32'd1) : a_q;
    assign b_mag = (sgn && b_q[31]) ? (~b_q + 32'd1) : b_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        dvs_d        = dvs_q;
        qneg_d       = qneg_q;
        rneg_d       = rneg_q;
        dz_d         = dz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = req_op;
                    a_d  = src_a;
                    b_d  = src_b;
                    case (req_op)
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        OP_DIV, OP_DIVU: state_d = S_DIV_PRE;
                        default: begin
                            state_d = S_MUL;
                            cnt_d   = 5'(MUL_LAT - 1);
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == 5'd0) begin
                    state_d = S_IDLE;
                    case (op_q)
                        OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                        OP_MUL: begin
                            resp_valid_d = 1'b1;
                            resp_data_d  = prod[31:0];
                        end
                        default: state_d = S_ACC;
                    endcase
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_ACC: begin
                {hi_d, lo_d} = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
                state_d      = S_IDLE;
            end
            S_DIV_PRE: begin
                quo_d   = a_mag;
                dvs_d   = b_mag;
                rem_d   = 32'd0;
                qneg_d  = sgn & (a_q[31] ^ b_q[31]);
                rneg_d  = sgn & a_q[31];
                dz_d    = (b_q == 32'd0);
                cnt_d   = 5'd31;
                state_d = (b_q == 32'd0) ? S_DIV_FIX : S_DIV_IT;
            end
            S_DIV_IT: begin
                rem_d = ge ? diff : shl[31:0];
                quo_d = {quo_q[30:0], ge};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = S_DIV_FIX;
            end
            S_DIV_FIX: begin
                if (dz_q) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = a_q;
                end else begin
                    lo_d = qneg_q ? (~quo_q + 32'd1) : quo_q;
                    hi_d = rneg_q ? (~rem_q + 32'd1) : rem_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over everything, including the edge that would write HI/LO.
        if (flush) begin
            state_d      = S_IDLE;
            hi_d         = hi_q;
            lo_d         = lo_q;
            resp_valid_d = 1'b0;
            resp_data_d  = resp_data_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            op_q         <= 4'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            cnt_q        <= 5'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            quo_q        <= 32'd0;
            rem_q        <= 32'd0;
            dvs_q        <= 32'd0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            dz_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            dvs_q        <= dvs_d;
            qneg_q       <= qneg_d;
            rneg_q       <= rneg_d;
            dz_q         <= dz_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the driver pushes expected HI/LO/latency/response
// per op, a negedge monitor pops and compares whenever busy falls.
module tb_mdu_ctrl;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0, resetn = 1'b0, req_valid = 1'b0, flush = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] src_a = 32'd0, src_b = 32'd0;
    logic        req_ready, busy, resp_valid;
    logic [31:0] hi, lo, resp_data;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
        .src_a(src_a), .src_b(src_b), .flush(flush), .req_ready(req_ready),
        .busy(busy), .hi(hi), .lo(lo), .resp_valid(resp_valid), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi, lo, rd;
        int          lat;
        bit          is_mul, flushed;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0, bad = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: busy falling marks the end of an op (or its flush).
    int bcnt = 0;
    bit pb = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            exp_q.delete();
            bcnt = 0;
            pb   = 1'b0;
        end else begin
            if (busy) bcnt++;
            if (pb && !busy) begin
                chk("pending_exp", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("hi", hi, e.hi);
                    chk("lo", lo, e.lo);
                    chk("busy_cycles", bcnt, e.lat);
                    if (e.is_mul && !e.flushed) begin
                        chk("resp_valid", resp_valid, 1);
                        chk("resp_data", resp_data, e.rd);
                    end else begin
                        chk("no_resp", resp_valid, 0);
                    end
                end
                bcnt = 0;
            end else if (resp_valid) begin
                chk("stray_resp", resp_valid, 0);
            end
            pb = busy;
        end
    end

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at the first idle negedge.
    // fl_k > 0 flushes during the fl_k-th busy cycle (clamped to the op length).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int fl_k);
        exp_t        e;
        longint      sa, sb, ua, ub, q, r;
        logic [63:0] p, acc;
        logic [31:0] nh, nl;
        bit          seqop, sg;
        int          n, k;
        sa = $signed(a); sb = $signed(b);
        ua = {32'd0, a}; ub = {32'd0, b};
        sg = op inside {4'd1, 4'd3, 4'd5, 4'd7, 4'd9};
        p  = sg ? 64'(sa * sb) : 64'(ua * ub);
        nh = m_hi; nl = m_lo;
        e.rd = 32'd0; e.is_mul = 1'b0; e.lat = 0; seqop = 1'b1;
        case (op)
            4'd1, 4'd2: begin {nh, nl} = p; e.lat = MUL_LAT; end
            4'd3, 4'd4: begin
                if (b == 32'd0) begin
                    nl = 32'hFFFF_FFFF; nh = a; e.lat = 2;
                end else begin
                    q = sg ? sa / sb : ua / ub;
                    r = sg ? sa % sb : ua % ub;
                    nl = q[31:0]; nh = r[31:0]; e.lat = 34;
                end
            end
            4'd5, 4'd6, 4'd7, 4'd8: begin
                acc = (op >= 4'd7) ? ({m_hi, m_lo} - p) : ({m_hi, m_lo} + p);
                {nh, nl} = acc; e.lat = MUL_LAT + 1;
            end
            4'd9:  begin e.is_mul = 1'b1; e.rd = p[31:0]; e.lat = MUL_LAT; end
            4'd10: begin nh = a; seqop = 1'b0; end
            4'd11: begin nl = a; seqop = 1'b0; end
            default: seqop = 1'b0;
        endcase
        k = (fl_k > e.lat) ? e.lat : fl_k;
        e.flushed = (k > 0);
        if (e.flushed) begin
            e.hi = m_hi; e.lo = m_lo; e.lat = k;
        end else begin
            e.hi = nh; e.lo = nl;
        end
        if (seqop) exp_q.push_back(e);
        req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
        @(negedge clk);
        req_valid = 1'b0; src_a = $urandom; src_b = $urandom;
        chk("accepted", busy, seqop);
        if (!seqop) begin
            chk("mt_hi", hi, nh);
            chk("mt_lo", lo, nl);
        end
        if (e.flushed) begin
            for (int i = 1; i < k; i++) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout", busy, 0);
        if (!e.flushed) begin
            m_hi = nh; m_lo = nl;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 1); chk("rst_rv", resp_valid, 0); chk("rst_rd", resp_data, 0);
        resetn = 1'b1;
        @(negedge clk);

        issue(4'd10, 32'h1234, 32'd0, 0);
        issue(4'd11, 32'h5678, 32'd0, 0);
        chk("mthi_const", hi, 32'h1234);
        chk("mtlo_const", lo, 32'h5678);
        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 0);
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 0);
        chk("multu_hi_const", hi, 32'h1);
        issue(4'd10, 32'd0, 32'd0, 0); issue(4'd11, 32'h10, 32'd0, 0);
        issue(4'd5, 32'd3, 32'd4, 0);
        chk("madd_lo_const", lo, 32'h1C);
        issue(4'd10, 32'd0, 32'd0, 0); issue(4'd11, 32'h10, 32'd0, 0);
        issue(4'd7, 32'd1, 32'h20, 0);
        chk("msub_hi_const", hi, 32'hFFFF_FFFF);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_lo_const", lo, 32'hFFFF_FFFD);
        issue(4'd4, 32'd7, 32'd0, 0);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("divovf_lo_const", lo, 32'h8000_0000);

        issue(4'd3, 32'd1000, 32'd7, 11);
        issue(4'd3, 32'd1000, 32'd7, 34);
        issue(4'd1, 32'd12345, 32'd678, MUL_LAT);
        issue(4'd5, 32'd9, 32'd9, MUL_LAT + 1);
        issue(4'd9, 32'd6, 32'd7, MUL_LAT);

        req_valid = 1'b1; req_op = 4'd3; src_a = 32'd50; src_b = 32'd5; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_req_busy", busy, 0); chk("flush_req_ready", req_ready, 1);
        chk("flush_req_hi", hi, m_hi); chk("flush_req_lo", lo, m_lo);

        issue(4'd9, 32'hFFFF_FFFF, 32'd5, 0);
        issue(4'd9, 32'd3, 32'd7, 0);
        issue(4'd0, 32'd1, 32'd1, 0);
        issue(4'd13, 32'd1, 32'd1, 0);

        req_valid = 1'b1; req_op = 4'd3; src_a = 32'd99; src_b = 32'd4;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mrst_hi", hi, 0); chk("mrst_lo", lo, 0); chk("mrst_busy", busy, 0);
        chk("mrst_ready", req_ready, 1);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 150; t++) begin
            logic [3:0] op;
            int         fk;
            op = 4'($urandom_range(0, 15));
            fk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 34)) : 0;
            issue(op, rnd32(), rnd32(), fk);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencing controller for the multiply/divide unit (MDU) and owner of the architectural HI/LO registers.
- Accepts one decoded MDU operation at a time from the issue stage: MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MUL/MTHI/MTLO.
- Drives an internal pipelined multiplier and an internal 32-iteration restoring divider.
- Reports busy so the issue stage stalls MFHI/MFLO and further MDU ops; MUL results return to the GPR writeback path.

Parameters:
MUL_LAT, 2, multiplier pipeline depth in cycles; legal range 1..4.

Ports:
clk  in  1  clock; all state updates on rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MUL, 10 MTHI, 11 MTLO, 12-15 reserved (treated as NONE)
src_a  in  32  rs operand
src_b  in  32  rt operand
flush  in  1  pipeline flush; aborts in-flight op
req_ready  out  1  controller can accept
busy  out  1  operation in flight; HI/LO not yet final
hi  out  32  architectural HI
lo  out  32  architectural LO
resp_valid  out  1  one-cycle pulse: MUL result valid
resp_data  out  32  MUL result (low 32 bits of signed product)

Behaviour:
- Reset (async, resetn=0): state IDLE; hi=0, lo=0, busy=0, req_ready=1, resp_valid=0, resp_data=0; all counters and divider registers 0.
- Accept = req_valid & req_ready & ~flush & op not NONE/reserved. req_ready = (state==IDLE).
- States: IDLE, MUL, ACC, DIV_PRE, DIV_IT, DIV_FIX.
- MTHI/MTLO: write hi/lo on the accepting edge; state stays IDLE; busy never asserts.
- MULT/MULTU/MUL: accept -> MUL for MUL_LAT cycles (down-counter), with busy=1.
  - Signed ops sign-extend the operands to 33 bits; unsigned ops zero-extend.
  - MULT/MULTU: {hi,lo} = 64-bit product on the edge leaving MUL.
  - MUL: hi/lo unchanged; resp_valid=1 with resp_data=product[31:0] in the first IDLE cycle.
- MADD*/MSUB*: MUL for MUL_LAT cycles, then ACC for 1 cycle: {hi,lo} <= {hi,lo} ± product, mod 2^64. Total busy = MUL_LAT+1 cycles.
- DIV/DIVU sequence:
  - DIV_PRE (1 cycle): latch magnitudes and result signs. The quotient is negative iff the operand signs differ; the remainder takes the sign of the dividend.
  - DIV_IT: 32 cycles (5-bit counter 31..0), one restoring step per cycle.
  - DIV_FIX (1 cycle): apply sign corrections; write lo=quotient, hi=remainder.
  - Busy = 34 cycles after accept.
- Divisor zero: DIV_PRE goes straight to DIV_FIX with lo=32'hFFFF_FFFF, hi=src_a unchanged (both DIV and DIVU). Busy = 2 cycles.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0; no exception.
- busy = (state!=IDLE); it drops in the same cycle hi/lo show the new value.
- flush: highest priority. In any state, the next state is IDLE and all in-flight results are discarded.
  - hi/lo keep their pre-op values; resp_valid is not issued.
  - flush in the same cycle as req_valid: the request is not accepted.
  - flush in the final cycle of an op (the edge that would write hi/lo) suppresses the write.
- Operands are latched at accept; src_a/src_b may change afterwards.
- Back-to-back: a new request may be accepted in the first IDLE cycle, including the cycle where resp_valid pulses.
- resetn asserted mid-operation: immediate return to the reset values above.

Test Plan:
- Reset, then MTHI a=0x1234 and next cycle MTLO a=0x5678 -> hi=0x1234, lo=0x5678; busy stays 0.
- MULT a=0xFFFF_FFFF b=2 -> after 2 cycles (MUL_LAT=2) hi=0xFFFF_FFFF, lo=0xFFFF_FFFE. MULTU with the same operands -> hi=0x1, lo=0xFFFF_FFFE.
- Preload hi=0, lo=0x10; MADD a=3 b=4 -> busy 3 cycles, then lo=0x1C, hi=0. MSUB a=1 b=0x20 from the same preload -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF0.
- DIV a=0xFFFF_FFF9 (-7) b=2 -> busy 34 cycles, then lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU a=7 b=0 -> 2 cycles, lo=0xFFFF_FFFF, hi=7. DIV 0x8000_0000 / -1 -> lo=0x8000_0000, hi=0.
- Start DIV, assert flush at DIV_IT cycle 10 -> next cycle req_ready=1, busy=0, hi/lo equal the pre-DIV values. Flush coincident with req_valid -> request ignored.
- MUL a=0xFFFF_FFFF (-1) b=5 followed immediately by a second MUL -> resp_valid one cycle with resp_data=0xFFFF_FFFB, hi/lo unchanged. The second request is accepted in the pulse cycle.
